// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: EX-stage request bus and HI/LO/busy result bus of the multiply/divide unit
interface mult_div_unit_if;
    logic        StartE;
    logic [2:0]  MdOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        BusyE;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output StartE, MdOpE, SrcAE, SrcBE, input BusyE, HI, LO);
    modport slave  (input StartE, MdOpE, SrcAE, SrcBE, output BusyE, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency MIPS multiply/divide unit with architectural HI/LO
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    mult_div_unit_if.slave md
);
    localparam int MAX_C = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] hi, hi_n, lo, lo_n, pend_hi, pend_hi_n, pend_lo, pend_lo_n;
    logic pend_we, pend_we_n;
    logic [31:0] a, b;
    logic [63:0] sprod, uprod;
    logic [31:0] abs_a, abs_b, ub, uq, ur, mq, mr, sq, sr;

    assign a = md.SrcAE;
    assign b = md.SrcBE;
    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};
    // Signed divide works on magnitudes so truncation toward zero and
    // 0x80000000 / -1 fall out naturally; a zero divisor is replaced by 1
    // only to keep the divider defined, its result is never committed.
    assign abs_a = a[31] ? -a : a;
    assign abs_b = (b == 32'd0) ? 32'd1 : (b[31] ? -b : b);
    assign ub = (b == 32'd0) ? 32'd1 : b;
    assign uq = a / ub;
    assign ur = a % ub;
    assign mq = abs_a / abs_b;
    assign mr = abs_a % abs_b;
    assign sq = (a[31] ^ b[31]) ? -mq : mq;
    assign sr = a[31] ? -mr : mr;

    assign md.BusyE = (state != IDLE);
    assign md.HI = hi;
    assign md.LO = lo;

    // State, counter, pending result and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi      <= hi_n;
            lo      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pend_we <= pend_we_n;
        end
    end

    // Accept requests in IDLE, count down while busy, commit on the last busy cycle
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi;
        lo_n      = lo;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pend_we_n = pend_we;
        case (state)
            IDLE: begin
                if (md.StartE) begin
                    case (md.MdOpE)
                        3'b000, 3'b001: begin
                            state_n = MUL;
                            cnt_n = CW'(MULT_CYCLES);
                            {pend_hi_n, pend_lo_n} = md.MdOpE[0] ? uprod : sprod;
                            pend_we_n = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            state_n = DIV;
                            cnt_n = CW'(DIV_CYCLES);
                            pend_lo_n = md.MdOpE[0] ? uq : sq;
                            pend_hi_n = md.MdOpE[0] ? ur : sr;
                            pend_we_n = (b != 32'd0);
                        end
                        3'b100: hi_n = a;
                        3'b101: lo_n = a;
                        default: ;
                    endcase
                end
            end
            default: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    if (pend_we) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                end
            end
        endcase
    end
endmodule
